input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 126 ++++++++++++
 tb/tb_input_conditioner.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Per-channel conditioning of raw asynchronous inputs: optional inversion, a synchronizer chain,
// a debounce counter, and registered edge, toggle and long-press pulses.
module input_conditioner #(
  parameter int                  Channels       = 3,
  parameter int                  SyncStages     = 2,
  parameter int                  DebounceCycles = 250000,
  parameter int                  HoldCycles     = 0,
  parameter logic [Channels-1:0] InvertMask     = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [Channels-1:0] raw_async_unsafe_i,
  output logic [Channels-1:0] level_o,
  output logic [Channels-1:0] rise_o,
  output logic [Channels-1:0] fall_o,
  output logic [Channels-1:0] toggle_o,
  output logic [Channels-1:0] hold_o
);

  localparam int              CntW    = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0][Channels-1:0] sync_q, sync_d;
  logic [Channels-1:0][CntW-1:0]       cnt_q, cnt_d;
  logic [Channels-1:0]                 level_q, level_d;
  logic [Channels-1:0]                 rise_q, rise_d;
  logic [Channels-1:0]                 fall_q, fall_d;
  logic [Channels-1:0]                 toggle_q, toggle_d;
  logic [Channels-1:0]                 synced;

  // Inversion is the only logic allowed ahead of the first synchronizer flop.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = raw_async_unsafe_i ^ InvertMask;
    for (int s = 1; s < SyncStages; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign synced = sync_q[SyncStages-1];

  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = '0;
    fall_d   = '0;
    toggle_d = toggle_q;
    for (int ch = 0; ch < Channels; ch++) begin
      if (synced[ch] == level_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CntLast) begin
        // The counter never passes CntLast: a mismatch here commits, a match clears.
        cnt_d[ch]   = '0;
        level_d[ch] = synced[ch];
        rise_d[ch]  = synced[ch];
        fall_d[ch]  = ~synced[ch];
        toggle_d[ch] = toggle_q[ch] ^ synced[ch];
      end else begin
        cnt_d[ch] = cnt_q[ch] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      toggle_q <= '0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign level_o  = level_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign toggle_o = toggle_q;

  if (HoldCycles > 0) begin : g_hold
    localparam int               HoldW    = $clog2(HoldCycles + 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(HoldCycles);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);

    logic [Channels-1:0][HoldW-1:0] hcnt_q, hcnt_d;
    logic [Channels-1:0]            hold_q, hold_d;

    // Counter parks at HoldMax so a press held indefinitely yields a single pulse.
    always_comb begin
      hcnt_d = hcnt_q;
      hold_d = '0;
      for (int ch = 0; ch < Channels; ch++) begin
        if (!level_q[ch]) begin
          hcnt_d[ch] = '0;
        end else begin
          if (hcnt_q[ch] < HoldMax) begin
            hcnt_d[ch] = hcnt_q[ch] + HoldW'(1);
          end
          hold_d[ch] = (hcnt_q[ch] == HoldLast);
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        hcnt_q <= '0;
        hold_q <= '0;
      end else begin
        hcnt_q <= hcnt_d;
        hold_q <= hold_d;
      end
    end

    assign hold_o = hold_q;
  end else begin : g_no_hold
    assign hold_o = '0;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (SyncStages=2, DebounceCycles=4, HoldCycles=10).
// Channel k of the scenarios maps to bit k-1; a second instance exercises an inverted channel 1.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] raw = '0;
  logic [2:0] raw_inv = '0;

  logic [2:0] level, rise, fall, toggle, hold;
  logic [2:0] level_inv, rise_inv, fall_inv, toggle_inv, hold_inv;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_a, cnt_b;

  input_conditioner #(
    .Channels(3), .SyncStages(2), .DebounceCycles(4), .HoldCycles(10), .InvertMask(3'b000)
  ) dut (
    .clk_i(clk), .rst_i(rst), .raw_async_unsafe_i(raw),
    .level_o(level), .rise_o(rise), .fall_o(fall), .toggle_o(toggle), .hold_o(hold)
  );

  input_conditioner #(
    .Channels(3), .SyncStages(2), .DebounceCycles(4), .HoldCycles(10), .InvertMask(3'b001)
  ) dut_inv (
    .clk_i(clk), .rst_i(rst), .raw_async_unsafe_i(raw_inv),
    .level_o(level_inv), .rise_o(rise_inv), .fall_o(fall_inv), .toggle_o(toggle_inv),
    .hold_o(hold_inv)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    step();
    step();
    check("rst_level", level, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_toggle", toggle, 0);
    check("rst_hold", hold, 0);
    check("rst_level_inv", level_inv, 0);
    rst = 1'b0;

    // Inverted ch1 held low through reset release qualifies after 6 edges with one rise
    cnt_a = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("inv_level", level_inv[0], (k >= 6));
      check("inv_rise", rise_inv[0], (k == 6));
      check("plain_quiet", level, 0);
      cnt_a += int'(rise_inv[0]);
    end
    check("inv_single_rise", cnt_a, 1);

    // ch1 press: rise at edge 6, then one hold pulse 10 cycles later
    raw[0] = 1'b1;
    cnt_a = 0;
    for (int k = 1; k <= 26; k++) begin
      step();
      check("ch1_level", level[0], (k >= 6));
      check("ch1_rise", rise[0], (k == 6));
      check("ch1_hold", hold[0], (k == 16));
      if (k == 6) check("ch1_toggle", toggle[0], 1);
      cnt_a += int'(hold[0]);
    end
    check("ch1_hold_count", cnt_a, 1);

    raw[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("ch1_rel_level", level[0], (k < 6));
      check("ch1_fall", fall[0], (k == 6));
      check("ch1_rel_toggle", toggle[0], 1);
    end

    // ch2 glitch of 3 cycles is discarded
    raw[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) raw[1] = 1'b0;
      step();
      check("ch2_glitch_level", level[1], 0);
      check("ch2_glitch_rise", rise[1], 0);
      check("ch2_glitch_fall", fall[1], 0);
    end

    // ch2 pulse of exactly 4 cycles passes the debouncer
    raw[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) raw[1] = 1'b0;
      step();
      check("ch2_min_level", level[1], (k >= 6 && k < 10));
      check("ch2_min_rise", rise[1], (k == 6));
      check("ch2_min_fall", fall[1], (k == 10));
      check("ch2_min_hold", hold[1], 0);
    end

    // ch3 two press/release cycles
    cnt_a = 0;
    cnt_b = 0;
    for (int p = 0; p < 2; p++) begin
      raw[2] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        step();
        check("ch3_excl", rise[2] & fall[2], 0);
        check("ch3_hold", hold[2], 0);
        cnt_a += int'(rise[2]);
        cnt_b += int'(fall[2]);
      end
      check("ch3_toggle", toggle[2], (p == 0));
      raw[2] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        step();
        check("ch3_excl", rise[2] & fall[2], 0);
        cnt_a += int'(rise[2]);
        cnt_b += int'(fall[2]);
      end
    end
    check("ch3_rise_count", cnt_a, 2);
    check("ch3_fall_count", cnt_b, 2);

    // Simultaneous events on ch1 and ch3; toggle was 3'b011 before
    raw = 3'b101;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("sim_rise", rise, (k == 6) ? 3'b101 : 3'b000);
      if (k == 6) check("sim_toggle", toggle, 3'b110);
    end
    raw = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("sim_fall", fall, (k == 6) ? 3'b101 : 3'b000);
      check("sim_hold", hold, 0);
    end

    // Reset 2 cycles into a ch1 debounce
    raw[0] = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_level", level, 0);
    check("mid_rst_rise", rise, 0);
    check("mid_rst_fall", fall, 0);
    check("mid_rst_toggle", toggle, 0);
    check("mid_rst_hold", hold, 0);
    check("mid_rst_toggle_inv", toggle_inv, 0);
    step();
    step();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("post_rst_level", level[0], (k >= 6));
      check("post_rst_rise", rise[0], (k == 6));
      check("post_rst_hold", hold[0], 0);
    end

    // Reset mid-hold: the hold count restarts after a fresh qualification
    rst = 1'b1;
    #1;
    check("hold_rst_level", level[0], 0);
    step();
    step();
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      check("rehold_level", level[0], (k >= 6));
      check("rehold_rise", rise[0], (k == 6));
      check("rehold_hold", hold[0], (k == 16));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
